axis_pkt_tx: RTL and testbench

- Master-side AXI4-Stream packet transmitter. Accepts a command of word address plus byte length.
- Fetches words from a 1-cycle-latency synchronous RAM read port and emits them as one AXI4S packet.
- Drives valid, data, keep and last; honours ready backpressure at full throughput.
- Sits between packet buffers and any AXI4S.Slave consumer (DMA egress, MAC tx).

---
 rtl/axis_pkg.sv | 30 +++
 rtl/axis_if.sv | 14 +
 rtl/axis_skid_buf2.sv | 64 ++++++
 rtl/axis_pkt_tx.sv | 153 +++++++++++++++
 tb/tb_axis_pkt_tx.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI4-Stream packet transmitter.
package axis_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tx_state_t;

    localparam int unsigned MAX_KEEP = 128;

    function automatic int unsigned beats_of(input int unsigned len, input int unsigned kw);
        return (len + kw - 1) / kw;
    endfunction

    // Keep mask for the final beat: low (len mod kw) bytes, or a full beat when the remainder is zero.
    function automatic logic [MAX_KEEP-1:0] last_keep(input int unsigned len, input int unsigned kw);
        logic [MAX_KEEP-1:0] m;
        int unsigned         rem;
        m   = '0;
        rem = len % kw;
        for (int unsigned i = 0; i < MAX_KEEP; i++) begin
            if ((i < kw) && ((rem == 0) || (i < rem))) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI4-Stream bundle: valid/data/keep/last flow master to slave, ready flows back.
interface axis_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;

    modport master (output valid, data, keep, last, input ready);
    modport slave  (input valid, data, keep, last, output ready);
endinterface

// File: rtl/axis_skid_buf2.sv
// Two-entry FIFO of {data, keep, last} whose head register drives the stream directly.
module axis_skid_buf2 #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [KEEP_WIDTH-1:0] keep_i,
    input  logic                  last_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [KEEP_WIDTH-1:0] keep_o,
    output logic                  last_o,
    output logic [1:0]            count_o
);
    localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;

    logic [EW-1:0] head_q, tail_q;
    logic          head_v_q, tail_v_q;
    logic [EW-1:0] in_word;
    logic          pop;

    assign in_word = {data_i, keep_i, last_i};
    assign pop     = head_v_q && ready_i;

    // The tail only fills when the head is stalled; a pop always refills the head from the tail first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q   <= '0;
            tail_q   <= '0;
            head_v_q <= 1'b0;
            tail_v_q <= 1'b0;
        end else if (!head_v_q) begin
            if (push_i) begin
                head_q   <= in_word;
                head_v_q <= 1'b1;
            end
        end else if (!tail_v_q) begin
            if (pop && push_i) begin
                head_q <= in_word;
            end else if (pop) begin
                head_v_q <= 1'b0;
            end else if (push_i) begin
                tail_q   <= in_word;
                tail_v_q <= 1'b1;
            end
        end else if (pop) begin
            head_q <= tail_q;
            if (push_i) begin
                tail_q <= in_word;
            end else begin
                tail_v_q <= 1'b0;
            end
        end
    end

    assign valid_o                  = head_v_q;
    assign {data_o, keep_o, last_o} = head_q;
    assign count_o                  = {1'b0, head_v_q} + {1'b0, tail_v_q};

endmodule

// File: rtl/axis_pkt_tx.sv
// AXI4-Stream packet transmitter: reads a packet from RAM and streams it out with keep/last.
// Optional packet/byte counters are built when AXIS_PKT_TX_STATS_EN is defined.
module axis_pkt_tx
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    axis_if.master                m_axis,
    output logic                  done,
`ifdef AXIS_PKT_TX_STATS_EN
    output logic [31:0]           stat_pkts,
    output logic [31:0]           stat_bytes,
`endif
    output tx_state_t             dbg_state
);
    tx_state_t             state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  beats_q, issued_q;
    logic [KEEP_WIDTH-1:0] lkeep_q, meta_keep_q;
    logic                  meta_last_q;
    logic                  rd_vld_q;
    logic                  done_q;

    logic                  cmd_fire, pop, credit, issue_last;
    logic [2:0]            occ_next;
    logic [1:0]            buf_count;
    logic                  buf_valid, buf_last;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [KEEP_WIDTH-1:0] buf_keep;

    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign pop        = buf_valid && m_axis.ready;

    // A read issued now lands one cycle later; reserve a slot for it even if ready drops meanwhile.
    assign occ_next   = 3'(buf_count) + 3'(rd_vld_q) - 3'(pop);
    assign credit     = occ_next < 3'd2;
    assign rd_en      = !rst && (state_q == RUN) && (issued_q != beats_q) && credit;
    assign rd_addr    = addr_q;
    assign issue_last = (issued_q == beats_q - LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            beats_q     <= '0;
            issued_q    <= '0;
            lkeep_q     <= '0;
            meta_keep_q <= '0;
            meta_last_q <= 1'b0;
            rd_vld_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rd_vld_q <= rd_en;
            if (rd_en) begin
                meta_last_q <= issue_last;
                meta_keep_q <= issue_last ? lkeep_q : '1;
                addr_q      <= addr_q + ADDR_WIDTH'(1);
                issued_q    <= issued_q + LEN_WIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        addr_q   <= cmd_addr;
                        beats_q  <= LEN_WIDTH'(beats_of(32'(cmd_len), KEEP_WIDTH));
                        lkeep_q  <= KEEP_WIDTH'(last_keep(32'(cmd_len), KEEP_WIDTH));
                        issued_q <= '0;
                        if (cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (rd_en && (issued_q + LEN_WIDTH'(1) == beats_q)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && buf_last) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    axis_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (rd_vld_q),
        .data_i  (rd_data),
        .keep_i  (meta_keep_q),
        .last_i  (meta_last_q),
        .ready_i (m_axis.ready),
        .valid_o (buf_valid),
        .data_o  (buf_data),
        .keep_o  (buf_keep),
        .last_o  (buf_last),
        .count_o (buf_count)
    );

    assign m_axis.valid = buf_valid;
    assign m_axis.data  = buf_data;
    assign m_axis.keep  = buf_keep;
    assign m_axis.last  = buf_last;
    assign done         = done_q;
    assign dbg_state    = state_q;

`ifdef AXIS_PKT_TX_STATS_EN
    logic [LEN_WIDTH-1:0] len_q;
    logic [31:0]          pkts_q, bytes_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            pkts_q  <= '0;
            bytes_q <= '0;
        end else begin
            if (cmd_fire) begin
                len_q <= cmd_len;
            end
            if (done_q) begin
                pkts_q  <= pkts_q + 32'd1;
                bytes_q <= bytes_q + 32'(len_q);
            end
        end
    end

    assign stat_pkts  = pkts_q;
    assign stat_bytes = bytes_q;
`endif

endmodule

// File: tb/tb_axis_pkt_tx.sv
// Bench for axis_pkt_tx: RAM model, ready driver, stream scoreboard and per-scenario tasks.
module tb_axis_pkt_tx;
    import axis_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic        done;
    tx_state_t   dbg_state;

    axis_if #(.DATA_WIDTH(32)) m_if ();

    axis_pkt_tx #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .LEN_WIDTH  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_axis    (m_if),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / environment ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [1024];

    function automatic logic [31:0] word_of(input logic [9:0] a);
        return {6'h2A, a, 6'h15, ~a};
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int ready_mode = 0;
    int rcnt = 0;
    initial m_if.ready = 1'b1;
    always @(posedge clk) begin
        #1;
        rcnt++;
        case (ready_mode)
            1:       m_if.ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
            2:       m_if.ready = 1'($urandom_range(0, 1));
            default: m_if.ready = 1'b1;
        endcase
    end

    // ---------------- scoreboard / monitor ----------------
    logic [36:0] exp_q[$];
    logic [9:0]  addr_log[$];
    int          pass_cnt = 0;
    int          chk_cnt = 0;
    int          done_cnt = 0, done_cyc = -1;
    int          beat_cnt = 0, last_hs_cyc = -1;
    int          rd_en_cnt = 0, valid_cnt = 0;
    int          first_valid_cyc = -1;
    int          max_count = 0;
    int          hs_cyc = 0;
    logic        stall_q = 1'b0;
    logic [36:0] held_q = '0;

    always @(negedge clk) begin
        logic [36:0] obs, e;
        obs = {m_if.data, m_if.keep, m_if.last};
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (rd_en) begin
                rd_en_cnt++;
                addr_log.push_back(rd_addr);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (int'(dut.u_buf.count_o) > max_count) max_count = int'(dut.u_buf.count_o);
            if (m_if.valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (stall_q) begin
                chk_cnt++;
                if (m_if.valid !== 1'b1 || obs !== held_q)
                    $display("FAIL stall_hold: valid=%b beat=%h required valid=1 beat=%h", m_if.valid, obs, held_q);
                else pass_cnt++;
            end
            if (m_if.valid && m_if.ready) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL beat_unexpected: beat=%h with no beat pending", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) $display("FAIL beat: got data/keep/last=%h required %h", obs, e);
                    else pass_cnt++;
                end
                beat_cnt++;
                last_hs_cyc = cyc;
            end
            stall_q = m_if.valid && !m_if.ready;
            held_q  = obs;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [9:0] a, input logic [15:0] l);
        int w, nb, rem;
        logic [3:0] lk, one;
        @(posedge clk); #1;
        w = 0;
        while (!cmd_ready && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 500) begin
            chk_cnt++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        nb  = (int'(l) + 3) / 4;
        rem = int'(l) % 4;
        one = 4'b0001;
        lk  = (rem == 0) ? 4'hF : 4'((one << rem) - 4'd1);
        for (int b = 0; b < nb; b++)
            exp_q.push_back({word_of(10'(a + 10'(b))), (b == nb - 1) ? lk : 4'hF, b == nb - 1});
        first_valid_cyc = -1;
        addr_log.delete();
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        @(posedge clk); #1;
        hs_cyc    = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int w;
        w = 0;
        while (done_cnt < target && w < budget) begin
            @(negedge clk);
            w++;
        end
        if (done_cnt < target) begin
            chk_cnt++;
            $display("FAIL done_timeout: done pulses=%0d required %0d", done_cnt, target);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b required 0", cmd_ready); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({m_if.valid, m_if.last, m_if.keep, m_if.data} !== 38'd0)
            $display("FAIL rst_stream: valid=%b last=%b keep=%h data=%h required all 0", m_if.valid, m_if.last, m_if.keep, m_if.data);
        else pass_cnt++;
        chk_cnt++;
        if (rd_en !== 1'b0 || rd_addr !== 10'd0 || done !== 1'b0)
            $display("FAIL rst_ram: rd_en=%b rd_addr=%h done=%b required 0 0 0", rd_en, rd_addr, done);
        else pass_cnt++;
        chk_cnt++;
        if (dbg_state !== IDLE || cmd_ready !== 1'b1)
            $display("FAIL rst_idle: state=%0d cmd_ready=%b required 0 1", dbg_state, cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        send_cmd(10'h010, 16'd10);
        wait_done(d0 + 1, 100);
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (first_valid_cyc !== hs_cyc + 2)
            $display("FAIL basic_latency: first valid cycle=%0d required %0d", first_valid_cyc, hs_cyc + 2);
        else pass_cnt++;
        chk_cnt++;
        if (done_cyc !== last_hs_cyc + 1)
            $display("FAIL basic_done_timing: done cycle=%0d required %0d", done_cyc, last_hs_cyc + 1);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt !== d0 + 1) $display("FAIL basic_done_count: got %0d required %0d", done_cnt, d0 + 1); else pass_cnt++;
        chk_cnt++;
        if (addr_log.size() != 3 || addr_log[0] !== 10'h010 || addr_log[1] !== 10'h011 || addr_log[2] !== 10'h012)
            $display("FAIL basic_rd_addr: %0d reads, first=%h required 3 reads 010..012", addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 10'h0);
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL basic_drained: %0d beats missing required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_len8();
        int d0, b0;
        d0 = done_cnt;
        b0 = beat_cnt;
        send_cmd(10'h020, 16'd8);
        wait_done(d0 + 1, 100);
        chk_cnt++;
        if (beat_cnt - b0 != 2 || exp_q.size() != 0)
            $display("FAIL len8_beats: got %0d beats, %0d pending required 2, 0", beat_cnt - b0, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_len0();
        int d0, r0, v0;
        @(negedge clk);
        d0 = done_cnt;
        r0 = rd_en_cnt;
        v0 = valid_cnt;
        send_cmd(10'h030, 16'd0);
        @(negedge clk);
        chk_cnt++;
        if (done !== 1'b1 || cmd_ready !== 1'b1)
            $display("FAIL len0_done: done=%b cmd_ready=%b required 1 1", done, cmd_ready);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (done !== 1'b0) $display("FAIL len0_pulse: done=%b required 0", done); else pass_cnt++;
        repeat (4) @(negedge clk);
        chk_cnt++;
        if (rd_en_cnt != r0 || valid_cnt != v0 || done_cnt != d0 + 1)
            $display("FAIL len0_quiet: reads=%0d valids=%0d dones=%0d required 0 0 1", rd_en_cnt - r0, valid_cnt - v0, done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int d0, b0;
        d0 = done_cnt;
        b0 = beat_cnt;
        max_count = 0;
        ready_mode = 1;
        send_cmd(10'h040, 16'd64);
        wait_done(d0 + 1, 400);
        ready_mode = 0;
        chk_cnt++;
        if (beat_cnt - b0 != 16 || exp_q.size() != 0)
            $display("FAIL bp_beats: got %0d beats, %0d pending required 16, 0", beat_cnt - b0, exp_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (max_count > 2) $display("FAIL bp_occupancy: max count=%0d required <=2", max_count); else pass_cnt++;
    endtask

    task automatic test_wrap();
        int d0;
        d0 = done_cnt;
        send_cmd(10'h3FE, 16'd16);
        wait_done(d0 + 1, 100);
        chk_cnt++;
        if (addr_log.size() != 4 || addr_log[0] !== 10'h3FE || addr_log[1] !== 10'h3FF ||
            addr_log[2] !== 10'h000 || addr_log[3] !== 10'h001)
            $display("FAIL wrap_rd_addr: %0d reads, third=%h required 3FE,3FF,000,001", addr_log.size(), (addr_log.size() > 2) ? addr_log[2] : 10'h0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int d0, b0, w;
        d0 = done_cnt;
        b0 = beat_cnt;
        send_cmd(10'h080, 16'd20);
        w = 0;
        while (beat_cnt < b0 + 2 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (beat_cnt < b0 + 2) begin
            chk_cnt++;
            $display("FAIL rmid_timeout: beats=%0d required 2", beat_cnt - b0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (cmd_ready !== 1'b0) $display("FAIL rmid_cmd_ready: got %b required 0", cmd_ready); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_cnt++;
        if (m_if.valid !== 1'b0 || dbg_state !== IDLE)
            $display("FAIL rmid_abandon: valid=%b state=%0d required 0 0", m_if.valid, dbg_state);
        else pass_cnt++;
        repeat (10) @(negedge clk);
        chk_cnt++;
        if (done_cnt != d0 || valid_cnt < 0)
            $display("FAIL rmid_no_done: done pulses=%0d required 0", done_cnt - d0);
        else pass_cnt++;
        b0 = beat_cnt;
        send_cmd(10'h090, 16'd4);
        wait_done(d0 + 1, 100);
        chk_cnt++;
        if (beat_cnt - b0 != 1 || exp_q.size() != 0)
            $display("FAIL rmid_single: got %0d beats, %0d pending required 1, 0", beat_cnt - b0, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int d0;
        logic [9:0]  a;
        logic [15:0] l;
        ready_mode = 2;
        for (int k = 0; k < 6; k++) begin
            d0 = done_cnt;
            a  = 10'($urandom_range(0, 1023));
            l  = 16'($urandom_range(1, 41));
            send_cmd(a, l);
            wait_done(d0 + 1, 600);
        end
        ready_mode = 0;
        repeat (4) @(negedge clk);
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL b2b_drained: %0d beats missing required 0", exp_q.size()); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = word_of(10'(i));
        test_reset();
        test_basic();
        test_len8();
        test_len0();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
